// File: rtl/top_lab_2.sv
// Basys 3 sign-changer top: shows switch value N (or -N) as sign plus hex magnitude.
// Optional INPUT_SYNC_EN adds a two-flop synchronizer ahead of the input register.
module top_lab_2 #(
    parameter int SCAN_BITS = 17
) (
    input  logic        clkin,
    input  logic        btnR,
    input  logic [15:0] sw,
    input  logic        btnU,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic [15:0] led
);

    logic [8:0]           w_capture;
    logic [7:0]           r_n;
    logic                 r_neg;
    logic [7:0]           w_v;
    logic                 w_s;
    logic [7:0]           w_m;
    logic [SCAN_BITS-1:0] r_cnt;
    logic [1:0]           w_k;
    logic [6:0]           w_pat;
    logic [3:0]           w_anNext;
    logic [6:0]           r_seg;
    logic [3:0]           r_an;
    logic                 w_unusedSw;

    assign w_unusedSw = ^sw[15:8];

`ifdef INPUT_SYNC_EN
    logic [8:0] r_sync1;
    logic [8:0] r_sync2;

    always_ff @(posedge clkin) begin
        if (btnR) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {btnU, sw[7:0]};
            r_sync2 <= r_sync1;
        end
    end

    assign w_capture = r_sync2;
`else
    assign w_capture = {btnU, sw[7:0]};
`endif

    always_ff @(posedge clkin) begin
        if (btnR) begin
            r_n   <= '0;
            r_neg <= 1'b0;
        end else begin
            r_n   <= w_capture[7:0];
            r_neg <= w_capture[8];
        end
    end

    // 0x80 negates to itself, so its magnitude is still 0x80 with the sign set.
    assign w_v = r_neg ? (~r_n + 8'd1) : r_n;
    assign w_s = w_v[7];
    assign w_m = w_s ? (~w_v + 8'd1) : w_v;

    assign led = {w_v[7], 7'b0000000, w_v};
    assign dp  = 1'b1;

    function automatic logic [6:0] hexSeg(input logic [3:0] h);
        logic [6:0] p;
        case (h)
            4'h0: p = 7'b1000000;
            4'h1: p = 7'b1111001;
            4'h2: p = 7'b0100100;
            4'h3: p = 7'b0110000;
            4'h4: p = 7'b0011001;
            4'h5: p = 7'b0010010;
            4'h6: p = 7'b0000010;
            4'h7: p = 7'b1111000;
            4'h8: p = 7'b0000000;
            4'h9: p = 7'b0010000;
            4'hA: p = 7'b0001000;
            4'hB: p = 7'b0000011;
            4'hC: p = 7'b1000110;
            4'hD: p = 7'b0100001;
            4'hE: p = 7'b0000110;
            default: p = 7'b0001110;
        endcase
        return p;
    endfunction

    assign w_k      = r_cnt[SCAN_BITS-1:SCAN_BITS-2];
    assign w_anNext = ~(4'b0001 << w_k);

    always_comb begin
        w_pat = 7'b1111111;
        case (w_k)
            2'd0: w_pat = hexSeg(w_m[3:0]);
            2'd1: w_pat = hexSeg(w_m[7:4]);
            2'd2: w_pat = w_s ? 7'b0111111 : 7'b1111111;
            default: w_pat = 7'b1111111;
        endcase
    end

    // seg and an are registered together so a digit never shows its neighbour's pattern.
    always_ff @(posedge clkin) begin
        if (btnR) begin
            r_cnt <= '0;
            r_seg <= 7'b1000000;
            r_an  <= 4'b1110;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            r_seg <= w_pat;
            r_an  <= w_anNext;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_top_lab_2.sv
// Self-checking bench for top_lab_2: behavioural model compared every cycle,
// directed test-plan cases with literal expectations, then randomized stimulus.
module tb_top_lab_2;

    localparam int SB = 4;
`ifdef INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clkin = 1'b0;
    logic        btnR;
    logic [15:0] sw;
    logic        btnU;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic [15:0] led;

    int nChecks = 0;
    int nPass   = 0;

    logic [6:0] hexTab [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int         mN, mNeg, mCnt, mS1, mS2;
    logic [6:0] mSeg;
    logic [3:0] mAn;
    bit         modelValid = 0;

    top_lab_2 #(.SCAN_BITS(SB)) dut (
        .clkin(clkin), .btnR(btnR), .sw(sw), .btnU(btnU),
        .seg(seg), .an(an), .dp(dp), .led(led)
    );

    always #5 clkin = ~clkin;

    function automatic int modelV(input int n, input int neg);
        return neg != 0 ? (256 - n) % 256 : n;
    endfunction

    function automatic int modelMag(input int v);
        return v >= 128 ? 256 - v : v;
    endfunction

    function automatic logic [15:0] modelLed(input int n, input int neg);
        int v;
        v = modelV(n, neg);
        return 16'(v) | (v >= 128 ? 16'h8000 : 16'h0000);
    endfunction

    function automatic logic [6:0] digitPattern(input int k, input int v);
        int m;
        m = modelMag(v);
        if (k == 0) return hexTab[m % 16];
        if (k == 1) return hexTab[m / 16];
        if (k == 2) return v >= 128 ? 7'b0111111 : 7'b1111111;
        return 7'b1111111;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic [15:0] swVal, input logic negVal);
        sw   = swVal;
        btnU = negVal;
    endtask

    // Model advances on each rising edge using the inputs that were stable at that edge.
    initial begin
        forever begin
            @(posedge clkin);
            if (btnR) begin
                mCnt = 0; mSeg = 7'b1000000; mAn = 4'b1110;
                mN = 0; mNeg = 0; mS1 = 0; mS2 = 0;
                modelValid = 1;
            end else begin
                int k;
                k    = (mCnt >> (SB - 2)) % 4;
                mSeg = digitPattern(k, modelV(mN, mNeg));
                mAn  = ~(4'b0001 << k);
                mCnt = (mCnt + 1) % (1 << SB);
`ifdef INPUT_SYNC_EN
                mN   = mS2 % 256;
                mNeg = mS2 / 256;
                mS2  = mS1;
                mS1  = int'(sw[7:0]) + (btnU ? 256 : 0);
`else
                mN   = int'(sw[7:0]);
                mNeg = btnU ? 1 : 0;
`endif
            end
        end
    end

    initial begin
        forever begin
            @(negedge clkin);
            if (modelValid) begin
                checkOutput("model_led", led, modelLed(mN, mNeg));
                checkOutput("model_seg", {9'd0, seg}, {9'd0, mSeg});
                checkOutput("model_an", {12'd0, an}, {12'd0, mAn});
                checkOutput("model_dp", {15'd0, dp}, 16'd1);
            end
        end
    end

    task automatic waitDigit(input logic [3:0] want, input logic [6:0] expSeg, input string name);
        bit found;
        found = 0;
        @(negedge clkin);
        for (int i = 0; i < (1 << SB) + 2; i++) begin
            if (an === want) begin
                found = 1;
                break;
            end
            @(negedge clkin);
        end
        if (!found) checkOutput({name, "_timeout"}, {12'd0, an}, {12'd0, want});
        else checkOutput(name, {9'd0, seg}, {9'd0, expSeg});
    endtask

    task automatic runCase(input logic [15:0] swVal, input logic negVal, input logic [15:0] expLed,
                           input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2);
        applyStimulus(swVal, negVal);
        repeat (LAT) @(negedge clkin);
        checkOutput("lit_led", led, expLed);
        waitDigit(4'b1110, d0, "lit_digit0");
        waitDigit(4'b1101, d1, "lit_digit1");
        waitDigit(4'b1011, d2, "lit_digit2");
        waitDigit(4'b0111, 7'b1111111, "lit_digit3");
    endtask

    initial begin
        btnR = 1'b1;
        applyStimulus(16'h0000, 1'b0);
        repeat (2) @(negedge clkin);
        btnR = 1'b0;
        checkOutput("rst_led", led, 16'h0000);
        checkOutput("rst_an", {12'd0, an}, 16'h000E);
        checkOutput("rst_seg", {9'd0, seg}, 16'h0040);
        checkOutput("rst_dp", {15'd0, dp}, 16'h0001);

        runCase(16'h0017, 1'b0, 16'h0017, 7'b1111000, 7'b1111001, 7'b1111111);
        runCase(16'h0017, 1'b1, 16'h80E9, 7'b1111000, 7'b1111001, 7'b0111111);
        runCase(16'h00A0, 1'b0, 16'h80A0, 7'b1000000, 7'b0000010, 7'b0111111);
        runCase(16'h00A0, 1'b1, 16'h0060, 7'b1000000, 7'b0000010, 7'b1111111);
        runCase(16'h0080, 1'b0, 16'h8080, 7'b1000000, 7'b0000000, 7'b0111111);
        runCase(16'h0080, 1'b1, 16'h8080, 7'b1000000, 7'b0000000, 7'b0111111);
        runCase(16'h0000, 1'b1, 16'h0000, 7'b1000000, 7'b1000000, 7'b1111111);
        runCase(16'hFF3C, 1'b0, 16'h003C, 7'b1000110, 7'b0110000, 7'b1111111);

        // Reset while digit 2 is lit must bring the scan back to digit 0.
        applyStimulus(16'h00FF, 1'b0);
        waitDigit(4'b1011, 7'b0111111, "mid_digit2");
        btnR = 1'b1;
        @(negedge clkin);
        btnR = 1'b0;
        checkOutput("mid_rst_an", {12'd0, an}, 16'h000E);
        checkOutput("mid_rst_led", led, 16'h0000);
        repeat (LAT) @(negedge clkin);
        checkOutput("mid_rel_led", led, 16'h80FF);

        for (int i = 0; i < 600; i++) begin
            @(negedge clkin);
            if ($urandom_range(0, 3) == 0) applyStimulus(16'($urandom), 1'($urandom));
            btnR = ($urandom_range(0, 63) == 0);
        end
        btnR = 1'b0;
        repeat (4) @(negedge clkin);

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
